// File: rtl/pcpi_pkg.sv
// Shared types for the two-requester PCPI round-robin arbiter.
package pcpi_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } pcpi_state_e;

  // Index of a requester port (0 or 1).
  typedef logic [0:0] req_idx_t;

endpackage

// File: rtl/pcpi_rr_arbiter_if.sv
// Bundle of the two requester ports, the shared coprocessor port and the error/status signals.
interface pcpi_rr_arbiter_if
  import pcpi_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);
  logic            req0_valid;
  logic [XLEN-1:0] req0_insn;
  logic [XLEN-1:0] req0_rs1;
  logic [XLEN-1:0] req0_rs2;
  logic            req0_ready;
  logic            req0_wr;
  logic [XLEN-1:0] req0_rd;
  logic            req0_wait;

  logic            req1_valid;
  logic [XLEN-1:0] req1_insn;
  logic [XLEN-1:0] req1_rs1;
  logic [XLEN-1:0] req1_rs2;
  logic            req1_ready;
  logic            req1_wr;
  logic [XLEN-1:0] req1_rd;
  logic            req1_wait;

  logic            cp_valid;
  logic [XLEN-1:0] cp_insn;
  logic [XLEN-1:0] cp_rs1;
  logic [XLEN-1:0] cp_rs2;
  logic            cp_ready;
  logic            cp_wr;
  logic            cp_wait;
  logic [XLEN-1:0] cp_rd;

  logic            err_clr;
  logic            busy;
  logic            timeout_err;

  // Arbiter side.
  modport master (
    input  req0_valid, req0_insn, req0_rs1, req0_rs2,
    output req0_ready, req0_wr, req0_rd, req0_wait,
    input  req1_valid, req1_insn, req1_rs1, req1_rs2,
    output req1_ready, req1_wr, req1_rd, req1_wait,
    output cp_valid, cp_insn, cp_rs1, cp_rs2,
    input  cp_ready, cp_wr, cp_wait, cp_rd,
    input  err_clr,
    output busy, timeout_err
  );

  // Requester/coprocessor side.
  modport slave (
    output req0_valid, req0_insn, req0_rs1, req0_rs2,
    input  req0_ready, req0_wr, req0_rd, req0_wait,
    output req1_valid, req1_insn, req1_rs1, req1_rs2,
    input  req1_ready, req1_wr, req1_rd, req1_wait,
    input  cp_valid, cp_insn, cp_rs1, cp_rs2,
    output cp_ready, cp_wr, cp_wait, cp_rd,
    output err_clr,
    input  busy, timeout_err
  );

endinterface

// File: rtl/pcpi_watchdog.sv
// Cycle counter that flags expiry on the TIMEOUT-th counted cycle; freeze holds the count.
module pcpi_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic freeze_i,
  output logic expired_o
);

  localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       step;

  assign step      = en_i && !freeze_i;
  assign expired_o = step && (cnt_q == LastCount);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pcpi_rr_arbiter.sv
// Round-robin arbiter sharing one PCPI coprocessor between two requesters, one command in
// flight, with a wait-aware watchdog that aborts stalled commands.
module pcpi_rr_arbiter
  import pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned XLEN    = XLEN_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  pcpi_rr_arbiter_if.master bus
);

  pcpi_state_e     state_q, state_d;
  req_idx_t        grant_q, grant_d;
  logic            cp_valid_q, cp_valid_d;
  logic [XLEN-1:0] cp_insn_q, cp_insn_d;
  logic [XLEN-1:0] cp_rs1_q, cp_rs1_d;
  logic [XLEN-1:0] cp_rs2_q, cp_rs2_d;
  logic [1:0]      ready_q, ready_d;
  logic [1:0]      wr_q, wr_d;
  logic [XLEN-1:0] rd0_q, rd0_d;
  logic [XLEN-1:0] rd1_q, rd1_d;
  logic            busy_q, busy_d;
  logic            timeout_err_q, timeout_err_d;

  logic wd_clr, wd_en, wd_expired;

  assign wd_en = (state_q == StIssue) && !bus.cp_ready;

  pcpi_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .freeze_i  (bus.cp_wait),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    cp_valid_d    = cp_valid_q;
    cp_insn_d     = cp_insn_q;
    cp_rs1_d      = cp_rs1_q;
    cp_rs2_d      = cp_rs2_q;
    ready_d       = '0;
    wr_d          = '0;
    rd0_d         = '0;
    rd1_d         = '0;
    wd_clr        = 1'b0;
    timeout_err_d = bus.err_clr ? 1'b0 : timeout_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req0_valid || bus.req1_valid) begin
          // Alternate only under contention; a lone requester always wins.
          if (bus.req0_valid && bus.req1_valid) begin
            grant_d = ~grant_q;
          end else begin
            grant_d = bus.req1_valid;
          end
          cp_insn_d  = (grant_d == 1'b1) ? bus.req1_insn : bus.req0_insn;
          cp_rs1_d   = (grant_d == 1'b1) ? bus.req1_rs1  : bus.req0_rs1;
          cp_rs2_d   = (grant_d == 1'b1) ? bus.req1_rs2  : bus.req0_rs2;
          cp_valid_d = 1'b1;
          wd_clr     = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        // cp_ready takes priority over a simultaneous watchdog expiry.
        if (bus.cp_ready || wd_expired) begin
          cp_valid_d       = 1'b0;
          state_d          = StResp;
          ready_d[grant_q] = 1'b1;
          wr_d[grant_q]    = bus.cp_ready & bus.cp_wr;
          if (bus.cp_ready) begin
            if (grant_q == 1'b1) begin
              rd1_d = bus.cp_rd;
            end else begin
              rd0_d = bus.cp_rd;
            end
          end else begin
            timeout_err_d = 1'b1;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      grant_q       <= 1'b1;
      cp_valid_q    <= 1'b0;
      cp_insn_q     <= '0;
      cp_rs1_q      <= '0;
      cp_rs2_q      <= '0;
      ready_q       <= '0;
      wr_q          <= '0;
      rd0_q         <= '0;
      rd1_q         <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      cp_valid_q    <= cp_valid_d;
      cp_insn_q     <= cp_insn_d;
      cp_rs1_q      <= cp_rs1_d;
      cp_rs2_q      <= cp_rs2_d;
      ready_q       <= ready_d;
      wr_q          <= wr_d;
      rd0_q         <= rd0_d;
      rd1_q         <= rd1_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.cp_valid    = cp_valid_q;
  assign bus.cp_insn     = cp_insn_q;
  assign bus.cp_rs1      = cp_rs1_q;
  assign bus.cp_rs2      = cp_rs2_q;
  assign bus.req0_ready  = ready_q[0];
  assign bus.req1_ready  = ready_q[1];
  assign bus.req0_wr     = wr_q[0];
  assign bus.req1_wr     = wr_q[1];
  assign bus.req0_rd     = rd0_q;
  assign bus.req1_rd     = rd1_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.req0_wait   = (state_q == StIssue) && (grant_q == 1'b0) && bus.cp_wait;
  assign bus.req1_wait   = (state_q == StIssue) && (grant_q == 1'b1) && bus.cp_wait;

endmodule

// File: tb/tb_pcpi_rr_arbiter.sv
// Randomized bench for pcpi_rr_arbiter: requesters keep pending commands, a reference model
// picks the expected winner from the pending set and the last grant.
module tb_pcpi_rr_arbiter;

  localparam int unsigned Timeout = 16;

  logic clk;
  logic rst_n;

  pcpi_rr_arbiter_if #(.XLEN(32)) bus ();

  pcpi_rr_arbiter #(
    .TIMEOUT (Timeout),
    .XLEN    (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending commands per requester and the last requester served.
  bit          pend [2];
  logic [31:0] p_insn [2];
  logic [31:0] p_rs1 [2];
  logic [31:0] p_rs2 [2];
  bit          last;

  function automatic logic rdy(input bit n);
    return n ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic wrf(input bit n);
    return n ? bus.req1_wr : bus.req0_wr;
  endfunction

  function automatic logic [31:0] rdf(input bit n);
    return n ? bus.req1_rd : bus.req0_rd;
  endfunction

  function automatic logic wtf(input bit n);
    return n ? bus.req1_wait : bus.req0_wait;
  endfunction

  task automatic drive_reqs();
    bus.req0_valid = pend[0];
    bus.req0_insn  = p_insn[0];
    bus.req0_rs1   = p_rs1[0];
    bus.req0_rs2   = p_rs2[0];
    bus.req1_valid = pend[1];
    bus.req1_insn  = p_insn[1];
    bus.req1_rs1   = p_rs1[1];
    bus.req1_rs2   = p_rs2[1];
  endtask

  task automatic raise(input bit n);
    pend[n]   = 1'b1;
    p_insn[n] = {n, 31'($urandom)};
    p_rs1[n]  = $urandom;
    p_rs2[n]  = $urandom;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    pend        = '{1'b0, 1'b0};
    p_insn      = '{32'h0, 32'h0};
    p_rs1       = '{32'h0, 32'h0};
    p_rs2       = '{32'h0, 32'h0};
    drive_reqs();
    bus.cp_ready = 1'b0;
    bus.cp_wr    = 1'b0;
    bus.cp_wait  = 1'b0;
    bus.cp_rd    = '0;
    bus.err_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last  = 1'b1;
  endtask

  // One command from IDLE: issue, optional wait cycles mid-flight, cp_ready, response pulse.
  task automatic do_txn(input int lat, input int nwait, input bit wr, input logic [31:0] rd);
    bit g;
    bit w;
    g = (pend[0] && pend[1]) ? !last : pend[1];
    @(posedge clk);
    #1;
    checks++;
    if (bus.cp_valid !== 1'b1)
      begin errors++; $display("FAIL issue_valid: got %b exp 1", bus.cp_valid); end
    checks++;
    if ({bus.cp_insn, bus.cp_rs1, bus.cp_rs2} !== {p_insn[g], p_rs1[g], p_rs2[g]}) begin
      errors++;
      $display("FAIL issue_cmd: got insn %h rs1 %h rs2 %h exp %h %h %h (req%0d)",
               bus.cp_insn, bus.cp_rs1, bus.cp_rs2, p_insn[g], p_rs1[g], p_rs2[g], g);
    end
    for (int i = 0; i < lat + nwait; i++) begin
      w = (i >= lat / 2) && (i < lat / 2 + nwait);
      bus.cp_wait = w;
      #1;
      checks++;
      if ({wtf(g), wtf(!g)} !== {w, 1'b0})
        begin errors++; $display("FAIL wait_fwd: got own %b other %b exp %b 0", wtf(g), wtf(!g), w); end
      checks++;
      if ({bus.cp_valid, bus.cp_insn, rdy(0), rdy(1)} !== {1'b1, p_insn[g], 2'b00}) begin
        errors++;
        $display("FAIL issue_hold: got valid %b insn %h rdy %b%b exp 1 %h 00",
                 bus.cp_valid, bus.cp_insn, rdy(1), rdy(0), p_insn[g]);
      end
      @(posedge clk);
      #1;
    end
    bus.cp_wait  = 1'b0;
    bus.cp_ready = 1'b1;
    bus.cp_wr    = wr;
    bus.cp_rd    = rd;
    @(posedge clk);
    #1;
    bus.cp_ready = 1'b0;
    bus.cp_wr    = 1'($urandom);
    bus.cp_rd    = $urandom;
    checks++;
    if ({bus.cp_valid, rdy(g), rdy(!g)} !== 3'b010)
      begin errors++; $display("FAIL resp_ready: got valid %b own %b other %b exp 0 1 0",
                               bus.cp_valid, rdy(g), rdy(!g)); end
    checks++;
    if ({wrf(g), rdf(g)} !== {wr, rd})
      begin errors++; $display("FAIL resp_data: got wr %b rd %h exp %b %h", wrf(g), rdf(g), wr, rd); end
    checks++;
    if ({wrf(!g), rdf(!g)} !== 33'h0)
      begin errors++; $display("FAIL other_zero: got wr %b rd %h exp 0 0", wrf(!g), rdf(!g)); end
    pend[g] = 1'b0;
    last    = g;
    drive_reqs();
    @(posedge clk);
    #1;
    checks++;
    if ({rdy(0), rdy(1), bus.busy, bus.req0_rd, bus.req1_rd} !== 67'h0)
      begin errors++; $display("FAIL resp_one_cycle: got rdy %b%b busy %b rd0 %h rd1 %h exp zeros",
                               rdy(1), rdy(0), bus.busy, bus.req0_rd, bus.req1_rd); end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.cp_valid, bus.cp_insn, bus.cp_rs1, bus.cp_rs2} !== 97'h0)
      begin errors++; $display("FAIL reset_cp: got valid %b insn %h rs1 %h rs2 %h exp zeros",
                               bus.cp_valid, bus.cp_insn, bus.cp_rs1, bus.cp_rs2); end
    checks++;
    if ({bus.req0_ready, bus.req0_wr, bus.req0_rd, bus.req1_ready, bus.req1_wr, bus.req1_rd} !== 68'h0)
      begin errors++; $display("FAIL reset_req: got rd0 %h rd1 %h rdy %b%b exp zeros",
                               bus.req0_rd, bus.req1_rd, bus.req1_ready, bus.req0_ready); end
    checks++;
    if ({bus.busy, bus.timeout_err, bus.req0_wait, bus.req1_wait} !== 4'h0)
      begin errors++; $display("FAIL reset_status: got busy %b err %b exp 0 0",
                               bus.busy, bus.timeout_err); end
  endtask

  task automatic test_single();
    pend[0]   = 1'b1;
    p_insn[0] = 32'h0200_0033;
    p_rs1[0]  = $urandom;
    p_rs2[0]  = $urandom;
    drive_reqs();
    do_txn(3, 0, 1'b1, 32'h1234_5678);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    raise(1'b0);
    raise(1'b1);
    drive_reqs();
    for (int k = 0; k < 4; k++) begin
      do_txn(int'($urandom_range(0, 6)), 0, 1'($urandom), $urandom);
      if (k < 2) begin
        raise(last);
        drive_reqs();
      end
    end
  endtask

  task automatic test_wait();
    raise(1'($urandom));
    drive_reqs();
    do_txn(0, 40, 1'b1, $urandom);
    raise(1'($urandom));
    drive_reqs();
    do_txn(12, 40, 1'b1, $urandom);
    checks++;
    if (bus.timeout_err !== 1'b0)
      begin errors++; $display("FAIL wait_no_timeout: got %b exp 0", bus.timeout_err); end
  endtask

  task automatic test_ready_at_expiry();
    raise(1'($urandom));
    drive_reqs();
    do_txn(int'(Timeout) - 1, 0, 1'b1, $urandom);
    raise(1'($urandom));
    drive_reqs();
    do_txn(int'(Timeout) - 1, 3, 1'b0, $urandom);
    checks++;
    if (bus.timeout_err !== 1'b0)
      begin errors++; $display("FAIL expiry_ready_wins: got err %b exp 0", bus.timeout_err); end
  endtask

  // Coprocessor never answers; wait cycles (after 8 counted cycles) must only pause the count.
  task automatic timeout_run(input int nwait, input bit hold_clr);
    bit g;
    int n;
    raise(1'($urandom));
    drive_reqs();
    g = (pend[0] && pend[1]) ? !last : pend[1];
    bus.err_clr = hold_clr;
    @(posedge clk);
    #1;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      bus.cp_wait = (c >= 8) && (c < 8 + nwait);
      if (bus.cp_valid !== 1'b1) break;
      n++;
      @(posedge clk);
      #1;
    end
    bus.cp_wait = 1'b0;
    bus.err_clr = 1'b0;
    checks++;
    if (n != int'(Timeout) + nwait)
      begin errors++; $display("FAIL abort_cycles: got %0d exp %0d", n, int'(Timeout) + nwait); end
    checks++;
    if ({rdy(g), rdy(!g), wrf(g), rdf(g)} !== {3'b100, 32'h0})
      begin errors++; $display("FAIL abort_resp: got own %b other %b wr %b rd %h exp 1 0 0 0",
                               rdy(g), rdy(!g), wrf(g), rdf(g)); end
    checks++;
    if (bus.timeout_err !== 1'b1)
      begin errors++; $display("FAIL err_set: got %b exp 1", bus.timeout_err); end
    pend[g] = 1'b0;
    last    = g;
    drive_reqs();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.timeout_err, bus.busy} !== 2'b10)
      begin errors++; $display("FAIL err_sticky: got err %b busy %b exp 1 0", bus.timeout_err, bus.busy); end
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    checks++;
    if (bus.timeout_err !== 1'b0)
      begin errors++; $display("FAIL err_clr: got %b exp 0", bus.timeout_err); end
  endtask

  task automatic test_timeout();
    timeout_run(0, 1'b0);
    timeout_run(5, 1'b0);
    timeout_run(0, 1'b1);
  endtask

  task automatic test_stray_ready();
    int pulses;
    pulses = 0;
    bus.cp_ready = 1'b1;
    bus.cp_wr    = 1'b1;
    bus.cp_rd    = $urandom;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.req0_ready || bus.req1_ready || bus.busy || bus.req0_rd != 0 || bus.req1_rd != 0)
        pulses++;
    end
    bus.cp_ready = 1'b0;
    checks++;
    if (pulses != 0)
      begin errors++; $display("FAIL stray_ready: got %0d active cycles exp 0", pulses); end
  endtask

  task automatic test_reset_mid_issue();
    int pulses;
    raise(1'b1);
    drive_reqs();
    @(posedge clk);
    #1;
    checks++;
    if ({bus.cp_valid, bus.cp_insn} !== {1'b1, p_insn[1]})
      begin errors++; $display("FAIL mid_issue_grant: got valid %b insn %h exp 1 %h",
                               bus.cp_valid, bus.cp_insn, p_insn[1]); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    pend  = '{1'b0, 1'b0};
    drive_reqs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last  = 1'b1;
    checks++;
    if ({bus.cp_valid, bus.busy, bus.cp_insn, bus.timeout_err} !== 35'h0)
      begin errors++; $display("FAIL reset_mid: got valid %b busy %b insn %h exp zeros",
                               bus.cp_valid, bus.busy, bus.cp_insn); end
    pulses = 0;
    repeat (4) begin
      if (bus.req0_ready || bus.req1_ready) pulses++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (pulses != 0)
      begin errors++; $display("FAIL no_pulse_after_reset: got %0d pulses exp 0", pulses); end
    raise(1'b0);
    raise(1'b1);
    drive_reqs();
    do_txn(2, 0, 1'b1, $urandom);
    do_txn(2, 0, 1'b1, $urandom);
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && ($urandom_range(0, 1) == 1)) raise(n[0]);
      end
      if (!pend[0] && !pend[1]) raise(1'($urandom));
      drive_reqs();
      do_txn(int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), 1'($urandom), $urandom);
    end
    pend = '{1'b0, 1'b0};
    drive_reqs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wait();
    test_ready_at_expiry();
    test_timeout();
    test_stray_ready();
    test_reset_mid_issue();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish exp finish");
    $fatal(1);
  end

endmodule

// File: doc/pcpi_rr_arbiter.md
PCPI_RR_ARBITER -- requirements
Module: pcpi_rr_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 16, coprocessor cycles allowed (cp_wait low) before abort; range 2..255.
REQ-002 Parameter: XLEN, 32, PCPI data/instruction width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 reqN_valid  in  1  (N=0,1) requester N command valid; held until reqN_ready.
REQ-006 reqN_insn, reqN_rs1, reqN_rs2  in  XLEN each  requester N instruction and operands.
REQ-007 reqN_ready  out  1  one-cycle completion pulse to requester N.
REQ-008 reqN_wr  out  1  result-valid flag, meaningful only with reqN_ready.
REQ-009 reqN_rd  out  XLEN  result, meaningful only with reqN_ready; 0 otherwise.
REQ-010 reqN_wait  out  1  coprocessor wait forwarded to granted requester.
REQ-011 cp_valid  out  1; cp_insn, cp_rs1, cp_rs2  out  XLEN each  shared coprocessor command port.
REQ-012 cp_ready, cp_wr, cp_wait  in  1 each; cp_rd  in  XLEN  coprocessor response.
REQ-013 err_clr  in  1  clears timeout_err; busy  out  1  state != IDLE; timeout_err  out  1  sticky abort flag.

Function
REQ-014 FSM states IDLE, ISSUE, RESP; one command in flight at a time.
REQ-015 IDLE: if any reqN_valid, grant per REQ-016, latch that requester's insn/rs1/rs2 into cp_* registers, set cp_valid, go ISSUE next edge.
REQ-016 Round-robin: both valid -> grant the requester not granted last; single valid -> grant it; last-grant pointer reset value favours req0 first.
REQ-017 ISSUE: cp_valid and cp_* held constant until cp_ready sampled high or timeout.
REQ-018 cp_ready high in ISSUE: clear cp_valid, latch cp_wr and cp_rd, go RESP on that edge.
REQ-019 RESP (exactly one cycle): reqG_ready=1, reqG_wr/reqG_rd = latched values (G = granted); then IDLE; new requests ignored during RESP.
REQ-020 Request-to-cp_valid latency 1 cycle; cp_ready-to-reqG_ready latency 1 cycle.
REQ-021 Requester must drop reqN_valid the cycle after reqN_ready; a valid still high in IDLE is a new command.
REQ-022 reqG_wait = cp_wait while in ISSUE, combinational; all outputs of the non-granted requester 0.
REQ-023 Watchdog counts ISSUE cycles with cp_ready=0 and cp_wait=0; frozen while cp_wait=1; cleared on entry to ISSUE.
REQ-024 Count reaching TIMEOUT: clear cp_valid, go RESP with wr=0, rd=0, set timeout_err.
REQ-025 cp_ready and timeout in the same cycle: cp_ready wins, no error set.
REQ-026 timeout_err clears only on err_clr=1 or reset; set and err_clr same cycle: set wins.
REQ-027 cp_ready outside ISSUE is ignored.

Reset
REQ-028 rst_n=0 at an edge: state IDLE, cp_valid=0, cp_* data 0, all reqN_ready/wr/rd 0, watchdog 0, timeout_err 0, busy 0, pointer favours req0.
REQ-029 Reset mid-ISSUE or RESP abandons the command; no reqN_ready pulse issued for it.

Structure
REQ-030 Shared package pcpi_pkg holds FSM state enum, XLEN default, requester-index type.
REQ-031 One sub-module pcpi_watchdog: counter with clear/enable/freeze inputs, TIMEOUT parameter, expired output.
REQ-032 All outputs except reqN_wait are registered.

Verification
REQ-033 req0 only, insn 0x0200_0033, cp_ready after 3 cycles with rd=0x1234_5678, wr=1 -> cp_valid 1 cycle after request, req0_ready one cycle with rd=0x1234_5678.
REQ-034 req0 and req1 valid same cycle, both held -> grants req0, req1, req0, req1 in order; each ready pulse only to its owner.
REQ-035 cp never responds, cp_wait=0, TIMEOUT=16 -> cp_valid drops after 16 ISSUE cycles, reqG_ready with wr=0 rd=0, timeout_err=1 until err_clr.
REQ-036 cp_wait=1 for 40 cycles then cp_ready -> no timeout, reqG_wait high throughout, normal completion.
REQ-037 rst_n low during ISSUE -> cp_valid 0 next edge, no ready pulse, next request granted to req0.
REQ-038 cp_ready on the cycle the watchdog expires -> normal completion, timeout_err stays 0.
